// File: rtl/regfile_pkg.sv
// Shared constants and entry type for the register-file write arbiter.
package regfile_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;

    // Hard-wired zero register: entries addressed here drain but never write.
    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = ADDR_WIDTH'(31);

    // One pending writeback: destination register and value.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_hold_buffer.sv
// One-entry holding register with a valid/ready input handshake.
// The entry can be drained and refilled in the same cycle.
module wb_hold_buffer
    import regfile_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      in_valid,
    output logic      in_ready,
    input  wb_entry_t in_entry,
    input  logic      drain,
    output logic      buf_valid,
    output wb_entry_t buf_entry,
    output logic      load
);

    logic      valid_reg;
    wb_entry_t entry_reg;

    // Ready only depends on occupancy and the drain, never on in_valid.
    assign in_ready  = !valid_reg || drain;
    assign load      = in_valid && in_ready;
    assign buf_valid = valid_reg;
    assign buf_entry = entry_reg;

    // Load wins over drain so a same-cycle drain+refill keeps the buffer full.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            entry_reg <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            entry_reg <= in_entry;
        end else if (drain) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the ALU writeback
// (req0) and the memory writeback (req1). Each requester has a one-entry
// buffer; a round-robin arbiter with oldest-first ordering on address
// conflicts drains them into a registered write stage.
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  stall,
    output logic                  RegWrite,
    output logic [ADDR_WIDTH-1:0] WriteRegister,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  busy
);

    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [1:0] buf_valid;
    logic [1:0] buf_load;
    logic [1:0] grant;
    wb_entry_t  in_entry  [2];
    wb_entry_t  buf_entry [2];
    wb_entry_t  grant_entry;

    // rr_reg: 0 -> req0 preferred. age_reg: 0 -> buffer 0 holds the older entry.
    logic rr_reg;
    logic age_reg;
    logic same_addr;

    logic                  reg_write_reg;
    logic [ADDR_WIDTH-1:0] write_register_reg;
    logic [DATA_WIDTH-1:0] write_data_reg;

    assign in_valid    = {req1_valid, req0_valid};
    assign in_entry[0] = {req0_addr, req0_data};
    assign in_entry[1] = {req1_addr, req1_data};
    assign req0_ready  = in_ready[0];
    assign req1_ready  = in_ready[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            wb_hold_buffer u_buf (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .in_entry  (in_entry[gi]),
                .drain     (grant[gi]),
                .buf_valid (buf_valid[gi]),
                .buf_entry (buf_entry[gi]),
                .load      (buf_load[gi])
            );
        end
    endgenerate

    assign same_addr = (buf_entry[0].addr == buf_entry[1].addr);

    // Grant selection: single valid buffer wins; on contention the older entry
    // wins when addresses collide, otherwise the round-robin pointer decides.
    always_comb begin
        grant = 2'b00;
        if (!stall) begin
            case (buf_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11: begin
                    if (same_addr) begin
                        grant = age_reg ? 2'b10 : 2'b01;
                    end else begin
                        grant = rr_reg ? 2'b10 : 2'b01;
                    end
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign grant_entry = grant[1] ? buf_entry[1] : buf_entry[0];

    // Round-robin pointer moves to the other requester after each grant; the
    // age bit marks whichever entry was resident when the other one arrived.
    // A same-cycle double load marks buffer 0 older so req1's value lands last.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_reg  <= 1'b0;
            age_reg <= 1'b0;
        end else begin
            if (grant[0]) begin
                rr_reg <= 1'b1;
            end else if (grant[1]) begin
                rr_reg <= 1'b0;
            end
            if (buf_load == 2'b11) begin
                age_reg <= 1'b0;
            end else if (buf_load[0] && buf_valid[1]) begin
                age_reg <= 1'b1;
            end else if (buf_load[1] && buf_valid[0]) begin
                age_reg <= 1'b0;
            end
        end
    end

    // Registered write stage; address/data hold when idle, zero-register
    // entries pass through with the write enable suppressed.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_reg      <= 1'b0;
            write_register_reg <= '0;
            write_data_reg     <= '0;
        end else if (|grant) begin
            reg_write_reg      <= (grant_entry.addr != ZERO_REG);
            write_register_reg <= grant_entry.addr;
            write_data_reg     <= grant_entry.data;
        end else begin
            reg_write_reg      <= 1'b0;
        end
    end

    assign RegWrite      = reg_write_reg;
    assign WriteRegister = write_register_reg;
    assign WriteData     = write_data_reg;
    assign busy          = (|buf_valid) | reg_write_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run scored against an architectural register-file model.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  req0_valid = 1'b0;
    logic                  req0_ready;
    logic [ADDR_WIDTH-1:0] req0_addr = '0;
    logic [DATA_WIDTH-1:0] req0_data = '0;
    logic                  req1_valid = 1'b0;
    logic                  req1_ready;
    logic [ADDR_WIDTH-1:0] req1_addr = '0;
    logic [DATA_WIDTH-1:0] req1_data = '0;
    logic                  stall = 1'b0;
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_addr     (req0_addr),
        .req0_data     (req0_data),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_addr     (req1_addr),
        .req1_data     (req1_data),
        .stall         (stall),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .busy          (busy)
    );

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        stall = 1'b0;
    endtask

    // Leaves the bench at a falling edge with the DUT freshly reset.
    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite actual=%0b expected=0", RegWrite); end
        checks++; if (WriteRegister !== '0) begin failures++; $display("FAIL reset_wreg actual=%0d expected=0", WriteRegister); end
        checks++; if (WriteData !== '0) begin failures++; $display("FAIL reset_wdata actual=%h expected=0", WriteData); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%0b expected=0", busy); end
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin failures++; $display("FAIL reset_ready actual=%0b%0b expected=11", req1_ready, req0_ready); end
        $display("txn reset done");
    endtask

    task automatic test_single_write();
        apply_reset();
        req0_valid = 1'b1; req0_addr = ADDR_WIDTH'(5); req0_data = 64'hDEAD_BEEF;
        @(negedge clk);
        idle_inputs();
        checks++; if (RegWrite !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_c1 actual=rw%0b busy%0b expected=rw0 busy1", RegWrite, busy); end
        @(negedge clk);
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== ADDR_WIDTH'(5) || WriteData !== 64'hDEAD_BEEF) begin
            failures++; $display("FAIL single_c2 actual=rw%0b a%0d d%h expected=rw1 a5 dDEADBEEF", RegWrite, WriteRegister, WriteData); end
        @(negedge clk);
        checks++; if (RegWrite !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_c3 actual=rw%0b busy%0b expected=rw0 busy0", RegWrite, busy); end
        $display("txn single write addr=5 data=deadbeef");
    endtask

    task automatic test_contention();
        int exp_seq[6] = '{1, 10, 2, 11, 3, 12};
        int got[$];
        logic r0_log[8];
        logic r1_log[8];
        int i0 = 0;
        int i1 = 0;
        apply_reset();
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (RegWrite === 1'b1) got.push_back(int'(WriteRegister));
            req0_valid = (i0 < 3); req0_addr = ADDR_WIDTH'(i0 + 1);  req0_data = DATA_WIDTH'(i0 + 100);
            req1_valid = (i1 < 3); req1_addr = ADDR_WIDTH'(i1 + 10); req1_data = DATA_WIDTH'(i1 + 200);
            #1;
            if (cyc < 8) begin r0_log[cyc] = req0_ready; r1_log[cyc] = req1_ready; end
            if (req0_valid && req0_ready) i0++;
            if (req1_valid && req1_ready) i1++;
            @(negedge clk);
        end
        idle_inputs();
        checks++; if (got.size() != 6) begin failures++; $display("FAIL contention_count actual=%0d expected=6", got.size()); end
        for (int k = 0; k < 6; k++) begin
            if (k < got.size()) begin
                checks++; if (got[k] != exp_seq[k]) begin failures++; $display("FAIL contention_order[%0d] actual=%0d expected=%0d", k, got[k], exp_seq[k]); end
            end
        end
        for (int c = 1; c < 6; c++) begin
            checks++;
            if (r0_log[c] !== logic'(c % 2 == 1) || r1_log[c] !== logic'(c % 2 == 0)) begin
                failures++; $display("FAIL contention_ready_c%0d actual=%0b%0b expected=%0b%0b", c, r1_log[c], r0_log[c], c % 2 == 0, c % 2 == 1);
            end
        end
        $display("txn contention writes=%0d", got.size());
    endtask

    task automatic test_same_addr();
        apply_reset();
        stall = 1'b1; req1_valid = 1'b1; req1_addr = ADDR_WIDTH'(7); req1_data = 64'h11;
        @(negedge clk);
        req1_valid = 1'b0; req0_valid = 1'b1; req0_addr = ADDR_WIDTH'(7); req0_data = 64'h22;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL sameaddr_ready actual=%0b%0b expected=01", req1_ready, req0_ready); end
        @(negedge clk);
        idle_inputs();
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL sameaddr_stalled actual=%0b expected=0", RegWrite); end
        @(negedge clk);
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== ADDR_WIDTH'(7) || WriteData !== 64'h11) begin
            failures++; $display("FAIL sameaddr_first actual=rw%0b a%0d d%h expected=rw1 a7 d11", RegWrite, WriteRegister, WriteData); end
        @(negedge clk);
        checks++; if (RegWrite !== 1'b1 || WriteData !== 64'h22) begin
            failures++; $display("FAIL sameaddr_second actual=rw%0b d%h expected=rw1 d22", RegWrite, WriteData); end
        $display("txn same-address older-first");

        apply_reset();
        req0_valid = 1'b1; req0_addr = ADDR_WIDTH'(7); req0_data = 64'hAA;
        req1_valid = 1'b1; req1_addr = ADDR_WIDTH'(7); req1_data = 64'hBB;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        checks++; if (RegWrite !== 1'b1 || WriteData !== 64'hAA) begin failures++; $display("FAIL samecycle_first actual=rw%0b d%h expected=rw1 dAA", RegWrite, WriteData); end
        @(negedge clk);
        checks++; if (RegWrite !== 1'b1 || WriteData !== 64'hBB) begin failures++; $display("FAIL samecycle_last actual=rw%0b d%h expected=rw1 dBB", RegWrite, WriteData); end
        $display("txn same-cycle same-address");
    endtask

    task automatic test_zero_reg();
        apply_reset();
        req0_valid = 1'b1; req0_addr = ZERO_REG; req0_data = 64'hFF;
        @(negedge clk);
        idle_inputs();
        checks++; if (RegWrite !== 1'b0 || busy !== 1'b1 || req0_ready !== 1'b1) begin
            failures++; $display("FAIL zero_c1 actual=rw%0b busy%0b rdy%0b expected=rw0 busy1 rdy1", RegWrite, busy, req0_ready); end
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            checks++; if (RegWrite !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b1) begin
                failures++; $display("FAIL zero_c%0d actual=rw%0b busy%0b rdy%0b expected=rw0 busy0 rdy1", c, RegWrite, busy, req0_ready); end
        end
        $display("txn zero-register write suppressed");
    endtask

    task automatic test_stall();
        apply_reset();
        stall = 1'b1;
        req0_valid = 1'b1; req0_addr = ADDR_WIDTH'(4); req0_data = 64'h44;
        req1_valid = 1'b1; req1_addr = ADDR_WIDTH'(9); req1_data = 64'h99;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (RegWrite !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL stall_c%0d actual=rw%0b rdy%0b%0b busy%0b expected=rw0 rdy00 busy1", c, RegWrite, req1_ready, req0_ready, busy); end
            if (c == 4) stall = 1'b0;
            @(negedge clk);
        end
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== ADDR_WIDTH'(4) || WriteData !== 64'h44) begin
            failures++; $display("FAIL stall_release1 actual=rw%0b a%0d d%h expected=rw1 a4 d44", RegWrite, WriteRegister, WriteData); end
        @(negedge clk);
        checks++; if (RegWrite !== 1'b1 || WriteRegister !== ADDR_WIDTH'(9) || WriteData !== 64'h99) begin
            failures++; $display("FAIL stall_release2 actual=rw%0b a%0d d%h expected=rw1 a9 d99", RegWrite, WriteRegister, WriteData); end
        @(negedge clk);
        checks++; if (RegWrite !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL stall_after actual=rw%0b busy%0b expected=rw0 busy0", RegWrite, busy); end
        $display("txn stall backpressure");
    endtask

    task automatic test_reset_midop();
        apply_reset();
        stall = 1'b1;
        req0_valid = 1'b1; req0_addr = ADDR_WIDTH'(12); req0_data = 64'h1212;
        req1_valid = 1'b1; req1_addr = ADDR_WIDTH'(13); req1_data = 64'h1313;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_full actual=%0b expected=1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; stall = 1'b0;
        checks++; if (RegWrite !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_after actual=rw%0b busy%0b expected=rw0 busy0", RegWrite, busy); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (RegWrite !== 1'b0 || WriteRegister !== '0) begin
                failures++; $display("FAIL midrst_quiet%0d actual=rw%0b a%0d expected=rw0 a0", c, RegWrite, WriteRegister); end
        end
        $display("txn reset mid-operation");
    endtask

    // Random traffic: every accepted entry updates the architectural model in
    // acceptance order (req0 before req1 within a cycle); each observed write
    // must be the next outstanding entry of one requester.
    task automatic test_random();
        logic [ADDR_WIDTH-1:0] addr_tab [5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
        logic [DATA_WIDTH-1:0] exp_rf [NUM_REGS];
        logic [DATA_WIDTH-1:0] dut_rf [NUM_REGS];
        wb_entry_t q0[$];
        wb_entry_t q1[$];
        int drained = 0;
        apply_reset();
        for (int r = 0; r < NUM_REGS; r++) begin exp_rf[r] = '0; dut_rf[r] = '0; end
        for (int cyc = 0; cyc < 430; cyc++) begin
            if (RegWrite === 1'b1) begin
                checks++;
                while (q0.size() > 0 && q0[0].addr == ZERO_REG) void'(q0.pop_front());
                while (q1.size() > 0 && q1[0].addr == ZERO_REG) void'(q1.pop_front());
                if (q0.size() > 0 && q0[0].addr == WriteRegister && q0[0].data == WriteData) begin
                    void'(q0.pop_front());
                end else if (q1.size() > 0 && q1[0].addr == WriteRegister && q1[0].data == WriteData) begin
                    void'(q1.pop_front());
                end else begin
                    failures++; $display("FAIL random_write_match actual=a%0d d%h expected=head of a requester queue", WriteRegister, WriteData);
                end
                dut_rf[WriteRegister] = WriteData;
                $display("txn random write addr=%0d data=%h", WriteRegister, WriteData);
            end
            if (cyc < 400) begin
                stall      = ($urandom_range(0, 4) == 0);
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_addr  = addr_tab[$urandom_range(0, 4)];
                req0_data  = {$urandom, $urandom};
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_addr  = addr_tab[$urandom_range(0, 4)];
                req1_data  = {$urandom, $urandom};
            end else begin
                idle_inputs();
                if (busy === 1'b0) begin drained = 1; break; end
            end
            #1;
            if (req0_valid && req0_ready) begin
                q0.push_back({req0_addr, req0_data});
                if (req0_addr != ZERO_REG) exp_rf[req0_addr] = req0_data;
            end
            if (req1_valid && req1_ready) begin
                q1.push_back({req1_addr, req1_data});
                if (req1_addr != ZERO_REG) exp_rf[req1_addr] = req1_data;
            end
            @(negedge clk);
        end
        checks++; if (drained != 1) begin failures++; $display("FAIL random_drain_timeout actual=busy%0b expected=idle within 30 cycles", busy); end
        while (q0.size() > 0 && q0[0].addr == ZERO_REG) void'(q0.pop_front());
        while (q1.size() > 0 && q1[0].addr == ZERO_REG) void'(q1.pop_front());
        checks++; if (q0.size() != 0 || q1.size() != 0) begin failures++; $display("FAIL random_lost_writes actual=%0d/%0d pending expected=0/0", q0.size(), q1.size()); end
        for (int r = 0; r < NUM_REGS - 1; r++) begin
            checks++; if (dut_rf[r] !== exp_rf[r]) begin failures++; $display("FAIL random_rf[%0d] actual=%h expected=%h", r, dut_rf[r], exp_rf[r]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_same_addr();
        test_zero_reg();
        test_stall();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
